// File: rtl/decode_pipe.sv
// RV32I/RV32E decode stage: IF/ID pipeline register, register file with writeback
// bypass, immediate generation, format classification and illegal-instruction detection.
module decode_pipe #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] I_PC,
    input  logic [31:0]     I_INST,
    input  logic            I_VALID,
    input  logic            W_VALID,
    input  logic [4:0]      W_REG,
    input  logic [XLEN-1:0] W_DATA,
    output logic [XLEN-1:0] D_PC,
    output logic [31:0]     D_INST,
    output logic            D_VALID,
    output logic [6:0]      D_OPCODE,
    output logic [2:0]      D_FUNCT3,
    output logic [6:0]      D_FUNCT7,
    output logic [2:0]      D_FMT,
    output logic [XLEN-1:0] D_IMM,
    output logic [4:0]      D_REG_D,
    output logic [4:0]      D_REG_S1,
    output logic [4:0]      D_REG_S2,
    output logic [XLEN-1:0] D_REG_S1_V,
    output logic [XLEN-1:0] D_REG_S2_V,
    output logic            D_ILLEGAL,
    input  logic [4:0]      DBG_SEL,
    output logic [XLEN-1:0] DBG_VAL
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [5:0]  NREG_LIM = 6'(NREG);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_e;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] s1_v, s2_v, dbg_v;
    fmt_e            fmt;
    logic [31:0]     imm32;
    logic            use_rs1, use_rs2, use_rd, bad;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREG_LIM;
    endfunction

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (FLUSH) begin
            valid_d = 1'b0;
            inst_d  = NOP;
        end else if (!STALL) begin
            pc_d    = I_PC;
            inst_d  = I_INST;
            valid_d = I_VALID;
        end
    end

    // Writeback ignores STALL/FLUSH; entries at or above NREG are never written.
    always_comb begin
        rf_d = rf_q;
        if (W_VALID && W_REG != 5'd0 && in_range(W_REG))
            rf_d[W_REG] = W_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= '0;
            inst_q  <= NOP;
            valid_q <= 1'b0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            rf_q    <= rf_d;
        end
    end

    assign rd  = inst_q[11:7];
    assign rs1 = inst_q[19:15];
    assign rs2 = inst_q[24:20];

    always_comb begin
        s1_v  = '0;
        s2_v  = '0;
        dbg_v = '0;
        if (rs1 != 5'd0 && in_range(rs1))
            s1_v = (BYPASS && W_VALID && W_REG == rs1) ? W_DATA : rf_q[rs1];
        if (rs2 != 5'd0 && in_range(rs2))
            s2_v = (BYPASS && W_VALID && W_REG == rs2) ? W_DATA : rf_q[rs2];
        if (DBG_SEL != 5'd0 && in_range(DBG_SEL))
            dbg_v = rf_q[DBG_SEL];
    end

    always_comb begin
        case (inst_q[6:0])
            7'b0110011:                                     fmt = FMT_R;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011:                         fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            default:                                        fmt = FMT_X;
        endcase
    end

    always_comb begin
        case (fmt)
            FMT_I:   imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
            FMT_S:   imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            FMT_B:   imm32 = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                              inst_q[11:8], 1'b0};
            FMT_U:   imm32 = {inst_q[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                              inst_q[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Only register fields the format actually uses can make an RV32E instruction illegal.
    always_comb begin
        use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
        use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
        use_rd  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
        bad     = (fmt == FMT_X)
                || (use_rs1 && !in_range(rs1))
                || (use_rs2 && !in_range(rs2))
                || (use_rd  && !in_range(rd));
    end

    assign D_PC       = pc_q;
    assign D_INST     = inst_q;
    assign D_VALID    = valid_q;
    assign D_OPCODE   = inst_q[6:0];
    assign D_FUNCT3   = inst_q[14:12];
    assign D_FUNCT7   = inst_q[31:25];
    assign D_FMT      = fmt;
    assign D_IMM      = XLEN'($signed(imm32));
    assign D_REG_D    = rd;
    assign D_REG_S1   = rs1;
    assign D_REG_S2   = rs2;
    assign D_REG_S1_V = s1_v;
    assign D_REG_S2_V = s2_v;
    assign D_ILLEGAL  = valid_q & bad;
    assign DBG_VAL    = dbg_v;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: three instances (RV32I with/without bypass, RV32E)
// share one stimulus stream; expectations are queued per cycle and checked by a monitor.
module tb_decode_pipe;

    localparam int S_VALID = 0, S_INST = 1, S_FMT = 2, S_IMM = 3, S_RD = 4, S_S1V = 5;
    localparam int S_S2V = 6, S_ILL = 7, S_DBG = 8, S_PC = 9, S_OPC = 10, S_F3 = 11;
    localparam int S_F7 = 12, S_RS1 = 13, S_RS2 = 14;

    typedef struct {
        int          cyc;
        int          dut;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, stall, flush, i_valid, w_valid;
    logic [31:0] i_pc, i_inst, w_data;
    logic [4:0]  w_reg, dbg_sel;

    logic [31:0] d_pc [3], d_inst [3], d_imm [3], s1_v [3], s2_v [3], dbg_val [3];
    logic        d_valid [3], d_illegal [3];
    logic [6:0]  d_opcode [3], d_funct7 [3];
    logic [2:0]  d_funct3 [3], d_fmt [3];
    logic [4:0]  d_rd [3], d_rs1 [3], d_rs2 [3];

    exp_t sb [$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    decode_pipe #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_i_byp (
        .CLK(clock), .RST(reset), .STALL(stall), .FLUSH(flush),
        .I_PC(i_pc), .I_INST(i_inst), .I_VALID(i_valid),
        .W_VALID(w_valid), .W_REG(w_reg), .W_DATA(w_data),
        .D_PC(d_pc[0]), .D_INST(d_inst[0]), .D_VALID(d_valid[0]),
        .D_OPCODE(d_opcode[0]), .D_FUNCT3(d_funct3[0]), .D_FUNCT7(d_funct7[0]),
        .D_FMT(d_fmt[0]), .D_IMM(d_imm[0]),
        .D_REG_D(d_rd[0]), .D_REG_S1(d_rs1[0]), .D_REG_S2(d_rs2[0]),
        .D_REG_S1_V(s1_v[0]), .D_REG_S2_V(s2_v[0]), .D_ILLEGAL(d_illegal[0]),
        .DBG_SEL(dbg_sel), .DBG_VAL(dbg_val[0])
    );

    decode_pipe #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_i_nobyp (
        .CLK(clock), .RST(reset), .STALL(stall), .FLUSH(flush),
        .I_PC(i_pc), .I_INST(i_inst), .I_VALID(i_valid),
        .W_VALID(w_valid), .W_REG(w_reg), .W_DATA(w_data),
        .D_PC(d_pc[1]), .D_INST(d_inst[1]), .D_VALID(d_valid[1]),
        .D_OPCODE(d_opcode[1]), .D_FUNCT3(d_funct3[1]), .D_FUNCT7(d_funct7[1]),
        .D_FMT(d_fmt[1]), .D_IMM(d_imm[1]),
        .D_REG_D(d_rd[1]), .D_REG_S1(d_rs1[1]), .D_REG_S2(d_rs2[1]),
        .D_REG_S1_V(s1_v[1]), .D_REG_S2_V(s2_v[1]), .D_ILLEGAL(d_illegal[1]),
        .DBG_SEL(dbg_sel), .DBG_VAL(dbg_val[1])
    );

    decode_pipe #(.XLEN(32), .NREG(16), .BYPASS(1'b1)) u_e_byp (
        .CLK(clock), .RST(reset), .STALL(stall), .FLUSH(flush),
        .I_PC(i_pc), .I_INST(i_inst), .I_VALID(i_valid),
        .W_VALID(w_valid), .W_REG(w_reg), .W_DATA(w_data),
        .D_PC(d_pc[2]), .D_INST(d_inst[2]), .D_VALID(d_valid[2]),
        .D_OPCODE(d_opcode[2]), .D_FUNCT3(d_funct3[2]), .D_FUNCT7(d_funct7[2]),
        .D_FMT(d_fmt[2]), .D_IMM(d_imm[2]),
        .D_REG_D(d_rd[2]), .D_REG_S1(d_rs1[2]), .D_REG_S2(d_rs2[2]),
        .D_REG_S1_V(s1_v[2]), .D_REG_S2_V(s2_v[2]), .D_ILLEGAL(d_illegal[2]),
        .DBG_SEL(dbg_sel), .DBG_VAL(dbg_val[2])
    );

    function automatic logic [31:0] getSig(input int d, input int s);
        case (s)
            S_VALID: return {31'b0, d_valid[d]};
            S_INST:  return d_inst[d];
            S_FMT:   return {29'b0, d_fmt[d]};
            S_IMM:   return d_imm[d];
            S_RD:    return {27'b0, d_rd[d]};
            S_S1V:   return s1_v[d];
            S_S2V:   return s2_v[d];
            S_ILL:   return {31'b0, d_illegal[d]};
            S_DBG:   return dbg_val[d];
            S_PC:    return d_pc[d];
            S_OPC:   return {25'b0, d_opcode[d]};
            S_F3:    return {29'b0, d_funct3[d]};
            S_F7:    return {25'b0, d_funct7[d]};
            S_RS1:   return {27'b0, d_rs1[d]};
            default: return {27'b0, d_rs2[d]};
        endcase
    endfunction

    function automatic void expectAt(input int c, input int d, input int s,
                                     input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = c;
        e.dut  = d;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [31:0] actual;
        actual = getSig(e.dut, e.sig);
        compared++;
        if (actual !== e.val) begin
            mismatched++;
            $display("[TB] FAIL %s (dut%0d, cycle %0d): got %h, expected %h",
                     e.name, e.dut, e.cyc, actual, e.val);
        end
    endtask

    task automatic monitorCycle();
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s: never sampled (due cycle %0d, now %0d)",
                         sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Monitor samples on the falling edge, half a cycle away from the register update.
    initial forever begin
        @(negedge clock);
        monitorCycle();
    end

    task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                 input logic iv, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic wv,
                                 input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [4:0] dbg);
        reset   = rst;
        stall   = stl;
        flush   = fl;
        i_valid = iv;
        i_pc    = pc;
        i_inst  = inst;
        w_valid = wv;
        w_reg   = wr;
        w_data  = wd;
        dbg_sel = dbg;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int c;
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h13, 0, 5'd0, 32'h0, 5'd0);
        tick();
        tick();
        c = cyc;
        expectAt(c, 0, S_VALID, 32'h0,  "rst_valid");
        expectAt(c, 0, S_INST,  32'h13, "rst_inst");
        expectAt(c, 0, S_FMT,   32'h1,  "rst_fmt");
        expectAt(c, 0, S_IMM,   32'h0,  "rst_imm");
        expectAt(c, 0, S_RD,    32'h0,  "rst_rd");
        expectAt(c, 0, S_S1V,   32'h0,  "rst_s1v");
        expectAt(c, 0, S_ILL,   32'h0,  "rst_illegal");
        expectAt(c, 0, S_DBG,   32'h0,  "rst_dbg");
        expectAt(c, 0, S_PC,    32'h0,  "rst_pc");

        // addi x1,x0,-1
        applyStimulus(0, 0, 0, 1, 32'h100, 32'hFFF00093, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_VALID, 32'h1,        "addi_valid");
        expectAt(c + 1, 0, S_PC,    32'h100,      "addi_pc");
        expectAt(c + 1, 0, S_FMT,   32'h1,        "addi_fmt");
        expectAt(c + 1, 0, S_IMM,   32'hFFFFFFFF, "addi_imm");
        expectAt(c + 1, 0, S_RD,    32'h1,        "addi_rd");
        expectAt(c + 1, 0, S_ILL,   32'h0,        "addi_illegal");
        expectAt(c + 1, 0, S_RS1,   32'h0,        "addi_rs1");
        tick();
        c = cyc;

        // add x3,x5,x5
        applyStimulus(0, 0, 0, 1, 32'h104, 32'h005281B3, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_FMT, 32'h0,  "add_fmt");
        expectAt(c + 1, 0, S_IMM, 32'h0,  "add_imm");
        expectAt(c + 1, 0, S_RD,  32'h3,  "add_rd");
        expectAt(c + 1, 0, S_RS1, 32'h5,  "add_rs1");
        expectAt(c + 1, 0, S_RS2, 32'h5,  "add_rs2");
        expectAt(c + 1, 0, S_OPC, 32'h33, "add_opcode");
        expectAt(c + 1, 0, S_F3,  32'h0,  "add_funct3");
        expectAt(c + 1, 0, S_F7,  32'h0,  "add_funct7");
        tick();
        c = cyc;

        // Writeback to x5 while add x3,x5,x5 is in decode
        applyStimulus(0, 0, 0, 1, 32'h104, 32'h005281B3, 1, 5'd5, 32'hDEADBEEF, 5'd5);
        expectAt(c, 0, S_S1V, 32'hDEADBEEF, "bypass_s1v");
        expectAt(c, 0, S_S2V, 32'hDEADBEEF, "bypass_s2v");
        expectAt(c, 1, S_S1V, 32'h0,        "nobypass_s1v");
        expectAt(c, 1, S_S2V, 32'h0,        "nobypass_s2v");
        expectAt(c, 0, S_DBG, 32'h0,        "dbg_no_bypass");
        expectAt(c, 2, S_S1V, 32'hDEADBEEF, "rv32e_bypass_s1v");
        tick();
        c = cyc;

        // add x3,x0,x0 next, and an attempted write to x0
        applyStimulus(0, 0, 0, 1, 32'h108, 32'h000001B3, 1, 5'd0, 32'h1234, 5'd5);
        expectAt(c, 1, S_S1V, 32'hDEADBEEF, "nobypass_late_s1v");
        expectAt(c, 1, S_S2V, 32'hDEADBEEF, "nobypass_late_s2v");
        expectAt(c, 0, S_DBG, 32'hDEADBEEF, "dbg_x5");
        expectAt(c, 1, S_DBG, 32'hDEADBEEF, "dbg_x5_nobyp");
        tick();
        c = cyc;

        applyStimulus(0, 0, 0, 1, 32'h200, 32'hFE000EE3, 1, 5'd0, 32'h1234, 5'd0);
        expectAt(c, 0, S_S1V, 32'h0, "x0_read_s1v");
        expectAt(c, 0, S_S2V, 32'h0, "x0_read_s2v");
        expectAt(c, 0, S_DBG, 32'h0, "dbg_x0");
        expectAt(c + 1, 0, S_FMT,   32'h3,        "beq_fmt");
        expectAt(c + 1, 0, S_IMM,   32'hFFFFFFFC, "beq_imm");
        expectAt(c + 1, 0, S_PC,    32'h200,      "beq_pc");
        expectAt(c + 1, 0, S_VALID, 32'h1,        "beq_valid");
        tick();
        c = cyc;

        // Three stalled cycles while fetch keeps changing
        applyStimulus(0, 1, 0, 1, 32'h300, 32'h8000006F, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_INST, 32'hFE000EE3, "stall1_inst");
        expectAt(c + 1, 0, S_PC,   32'h200,      "stall1_pc");
        tick();
        c = cyc;
        applyStimulus(0, 1, 0, 1, 32'h304, 32'h12345037, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_INST, 32'hFE000EE3, "stall2_inst");
        expectAt(c + 1, 0, S_FMT,  32'h3,        "stall2_fmt");
        tick();
        c = cyc;
        applyStimulus(0, 1, 0, 1, 32'h308, 32'h0000007F, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_INST,  32'hFE000EE3, "stall3_inst");
        expectAt(c + 1, 0, S_PC,    32'h200,      "stall3_pc");
        expectAt(c + 1, 0, S_VALID, 32'h1,        "stall3_valid");
        tick();
        c = cyc;

        // FLUSH outranks STALL; PC is left as it was
        applyStimulus(0, 1, 1, 1, 32'h30C, 32'h8000006F, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_VALID, 32'h0,   "flush_valid");
        expectAt(c + 1, 0, S_INST,  32'h13,  "flush_inst");
        expectAt(c + 1, 0, S_PC,    32'h200, "flush_pc");
        expectAt(c + 1, 0, S_ILL,   32'h0,   "flush_illegal");
        expectAt(c + 1, 0, S_FMT,   32'h1,   "flush_fmt");
        tick();
        c = cyc;

        // add x17,x1,x2 plus a write to x20: both out of range for RV32E
        applyStimulus(0, 0, 0, 1, 32'h400, 32'h002088B3, 1, 5'd20, 32'hCAFEF00D, 5'd20);
        expectAt(c + 1, 2, S_ILL, 32'h1,  "rv32e_rd17_illegal");
        expectAt(c + 1, 0, S_ILL, 32'h0,  "rv32i_rd17_legal");
        expectAt(c + 1, 2, S_RD,  32'h11, "rv32e_rd17_field");
        tick();
        c = cyc;

        applyStimulus(0, 0, 0, 1, 32'h404, 32'h0000007F, 0, 5'd0, 32'h0, 5'd20);
        expectAt(c, 0, S_DBG, 32'hCAFEF00D, "rv32i_dbg_x20");
        expectAt(c, 2, S_DBG, 32'h0,        "rv32e_dbg_x20_dropped");
        expectAt(c + 1, 0, S_FMT, 32'h7, "unknown_fmt");
        expectAt(c + 1, 0, S_ILL, 32'h1, "unknown_illegal");
        expectAt(c + 1, 2, S_FMT, 32'h7, "rv32e_unknown_fmt");
        expectAt(c + 1, 2, S_ILL, 32'h1, "rv32e_unknown_illegal");
        tick();
        c = cyc;

        applyStimulus(0, 0, 0, 0, 32'h408, 32'h0000007F, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_VALID, 32'h0, "invalid_slot_valid");
        expectAt(c + 1, 0, S_ILL,   32'h0, "invalid_slot_illegal");
        tick();
        c = cyc;

        // jal x0 with only the sign bit set
        applyStimulus(0, 0, 0, 1, 32'h40C, 32'h8000006F, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_FMT, 32'h5,        "jal_fmt");
        expectAt(c + 1, 0, S_IMM, 32'hFFF00000, "jal_imm");
        expectAt(c + 1, 0, S_RD,  32'h0,        "jal_rd");
        tick();
        c = cyc;

        applyStimulus(0, 0, 0, 1, 32'h410, 32'h12345037, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_FMT, 32'h4,        "lui_fmt");
        expectAt(c + 1, 0, S_IMM, 32'h12345000, "lui_imm");
        tick();
        c = cyc;

        // sw x1,-4(x2)
        applyStimulus(0, 0, 0, 1, 32'h414, 32'hFE112E23, 0, 5'd0, 32'h0, 5'd0);
        expectAt(c + 1, 0, S_FMT, 32'h2,        "sw_fmt");
        expectAt(c + 1, 0, S_IMM, 32'hFFFFFFFC, "sw_imm");
        expectAt(c + 1, 0, S_F3,  32'h2,        "sw_funct3");
        expectAt(c + 1, 0, S_RS1, 32'h2,        "sw_rs1");
        expectAt(c + 1, 0, S_RS2, 32'h1,        "sw_rs2");
        tick();
        c = cyc;

        // Reset coinciding with a write: the write to x7 is lost, x5 is cleared
        applyStimulus(1, 0, 0, 1, 32'h418, 32'hFFF00093, 1, 5'd7, 32'h55, 5'd5);
        expectAt(c + 1, 0, S_VALID, 32'h0,  "rst2_valid");
        expectAt(c + 1, 0, S_INST,  32'h13, "rst2_inst");
        expectAt(c + 1, 0, S_PC,    32'h0,  "rst2_pc");
        tick();
        c = cyc;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h13, 0, 5'd0, 32'h0, 5'd7);
        expectAt(c, 0, S_DBG, 32'h0, "rst2_write_lost");
        expectAt(c, 1, S_DBG, 32'h0, "rst2_write_lost_nobyp");
        tick();
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h13, 0, 5'd0, 32'h0, 5'd5);
        c = cyc;
        expectAt(c, 0, S_DBG, 32'h0, "rst2_x5_cleared");
        tick();
        tick();

        while (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: left unchecked (due cycle %0d)", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
